// File: rtl/debug_pkg.sv
// Shared types for the multi-hart debug run-control engine.
package debug_pkg;

  typedef enum logic [2:0] {
    HART_RUNNING,
    HART_HALT_PEND,
    HART_HALTED,
    HART_RESUME_PEND,
    HART_RESET_PEND
  } hart_run_state_t;

  typedef struct packed {
    logic halted;
    logic running;
    logic resumeack;
    logic havereset;
    logic unavail;
  } hart_status_t;

endpackage

// File: rtl/debug_hart_fsm.sv
// Per-hart run-control FSM: halt/resume/reset handshakes with ack timeout and sticky status flags.
module debug_hart_fsm
  import debug_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         haltreq_i,
  input  logic         resumereq_i,
  input  logic         hartreset_i,
  input  logic         ackhavereset_i,
  input  logic         halt_ack_i,
  input  logic         resume_ack_i,
  input  logic         reset_ack_i,
  output logic         hart_halt_o,
  output logic         hart_resume_o,
  output logic         hart_reset_o,
  output hart_status_t status_o
);

  localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

  hart_run_state_t    state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic               halt_q, halt_d;
  logic               resume_q, resume_d;
  logic               reset_q, reset_d;
  logic               resumeack_q, resumeack_d;
  logic               havereset_q, havereset_d;
  logic               unavail_q, unavail_d;
  logic               timeout;

  assign timer_inc = timer_q + 1'b1;
  assign timeout   = (timer_inc == TIMER_W'(ACK_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    halt_d      = 1'b0;
    resume_d    = 1'b0;
    reset_d     = 1'b0;
    resumeack_d = resumeack_q;
    havereset_d = havereset_q;
    unavail_d   = unavail_q;

    // A reset completion later in this block overrides this clear.
    if (ackhavereset_i) havereset_d = 1'b0;

    if (hartreset_i) begin
      state_d = HART_RESET_PEND;
      reset_d = 1'b1;
      timer_d = '0;
    end else begin
      unique case (state_q)
        HART_RUNNING: begin
          if (haltreq_i) begin
            state_d = HART_HALT_PEND;
            halt_d  = 1'b1;
            timer_d = '0;
          end
        end
        HART_HALT_PEND: begin
          if (halt_ack_i) begin
            state_d   = HART_HALTED;
            unavail_d = 1'b0;
          end else if (timeout) begin
            state_d   = HART_RUNNING;
            unavail_d = 1'b1;
          end else begin
            halt_d  = 1'b1;
            timer_d = timer_inc;
          end
        end
        HART_HALTED: begin
          if (resumereq_i && !haltreq_i) begin
            state_d     = HART_RESUME_PEND;
            resume_d    = 1'b1;
            resumeack_d = 1'b0;
            timer_d     = '0;
          end
        end
        HART_RESUME_PEND: begin
          if (resume_ack_i) begin
            state_d     = HART_RUNNING;
            resumeack_d = 1'b1;
            unavail_d   = 1'b0;
          end else if (timeout) begin
            state_d   = HART_HALTED;
            unavail_d = 1'b1;
          end else begin
            resume_d = 1'b1;
            timer_d  = timer_inc;
          end
        end
        HART_RESET_PEND: begin
          // Reached only once hartreset has been released.
          if (reset_ack_i) begin
            state_d     = HART_RUNNING;
            havereset_d = 1'b1;
            resumeack_d = 1'b0;
            unavail_d   = 1'b0;
          end else if (timeout) begin
            state_d   = HART_RUNNING;
            unavail_d = 1'b1;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: state_d = HART_RUNNING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HART_RUNNING;
      timer_q     <= '0;
      halt_q      <= 1'b0;
      resume_q    <= 1'b0;
      reset_q     <= 1'b0;
      resumeack_q <= 1'b0;
      havereset_q <= 1'b1;
      unavail_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      halt_q      <= halt_d;
      resume_q    <= resume_d;
      reset_q     <= reset_d;
      resumeack_q <= resumeack_d;
      havereset_q <= havereset_d;
      unavail_q   <= unavail_d;
    end
  end

  assign hart_halt_o        = halt_q;
  assign hart_resume_o      = resume_q;
  assign hart_reset_o       = reset_q;
  assign status_o.halted    = (state_q == HART_HALTED);
  assign status_o.running   = (state_q == HART_RUNNING) || (state_q == HART_HALT_PEND);
  assign status_o.resumeack = resumeack_q;
  assign status_o.havereset = havereset_q;
  assign status_o.unavail   = unavail_q;

endmodule

// File: rtl/debug_hart_run_ctrl.sv
// Multi-hart run control: hart selection decode, request fan-out to per-hart FSMs, dmstatus aggregation.
module debug_hart_run_ctrl
  import debug_pkg::*;
#(
  parameter int NUM_HARTS   = 4,
  parameter int HARTSEL_W   = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [HARTSEL_W-1:0] hartsel,
  input  logic                 hasel,
  input  logic [NUM_HARTS-1:0] hamask,
  input  logic                 haltreq,
  input  logic                 resumereq,
  input  logic                 hartreset,
  input  logic                 ackhavereset,
  input  logic [NUM_HARTS-1:0] hart_halt_ack,
  input  logic [NUM_HARTS-1:0] hart_resume_ack,
  input  logic [NUM_HARTS-1:0] hart_reset_ack,
  output logic [NUM_HARTS-1:0] hart_halt,
  output logic [NUM_HARTS-1:0] hart_resume,
  output logic [NUM_HARTS-1:0] hart_reset,
  output logic                 st_anyhalted,
  output logic                 st_allhalted,
  output logic                 st_anyrunning,
  output logic                 st_allrunning,
  output logic                 st_anyresumeack,
  output logic                 st_allresumeack,
  output logic                 st_anyhavereset,
  output logic                 st_allhavereset,
  output logic                 st_anyunavail,
  output logic                 st_allunavail,
  output logic                 st_nonexistent
);

  logic [NUM_HARTS-1:0] onehot, sel;
  logic                 sel_any;
  logic [NUM_HARTS-1:0] halted_v, running_v, resumeack_v, havereset_v, unavail_v;
  hart_status_t         status [NUM_HARTS];

  // Ids at or beyond NUM_HARTS decode to no hart at all.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      onehot[i] = (int'(hartsel) == i);
    end
  end

  assign sel            = onehot | (hasel ? hamask : '0);
  assign sel_any        = |sel;
  assign st_nonexistent = (int'(hartsel) >= NUM_HARTS);

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
    debug_hart_fsm #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_fsm (
      .clk            (clk),
      .rst_n          (rst_n),
      .haltreq_i      (haltreq & sel[g]),
      .resumereq_i    (resumereq & sel[g]),
      .hartreset_i    (hartreset & sel[g]),
      .ackhavereset_i (ackhavereset & sel[g]),
      .halt_ack_i     (hart_halt_ack[g]),
      .resume_ack_i   (hart_resume_ack[g]),
      .reset_ack_i    (hart_reset_ack[g]),
      .hart_halt_o    (hart_halt[g]),
      .hart_resume_o  (hart_resume[g]),
      .hart_reset_o   (hart_reset[g]),
      .status_o       (status[g])
    );

    assign halted_v[g]    = status[g].halted;
    assign running_v[g]   = status[g].running;
    assign resumeack_v[g] = status[g].resumeack;
    assign havereset_v[g] = status[g].havereset;
    assign unavail_v[g]   = status[g].unavail;
  end

  // all* requires at least one selected hart; unselected harts are masked to 1.
  assign st_anyhalted    = |(halted_v & sel);
  assign st_allhalted    = sel_any & (&(halted_v | ~sel));
  assign st_anyrunning   = |(running_v & sel);
  assign st_allrunning   = sel_any & (&(running_v | ~sel));
  assign st_anyresumeack = |(resumeack_v & sel);
  assign st_allresumeack = sel_any & (&(resumeack_v | ~sel));
  assign st_anyhavereset = |(havereset_v & sel);
  assign st_allhavereset = sel_any & (&(havereset_v | ~sel));
  assign st_anyunavail   = |(unavail_v & sel);
  assign st_allunavail   = sel_any & (&(unavail_v | ~sel));

endmodule

// File: tb/tb_debug_hart_run_ctrl.sv
// Scoreboard bench for debug_hart_run_ctrl with four harts and an 8-cycle ack timeout.
module tb_debug_hart_run_ctrl;

  localparam int NH = 4;
  localparam int HW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] hartsel;
  logic          hasel;
  logic [NH-1:0] hamask;
  logic          haltreq, resumereq, hartreset, ackhavereset;
  logic [NH-1:0] hart_halt_ack, hart_resume_ack, hart_reset_ack;
  logic [NH-1:0] hart_halt, hart_resume, hart_reset;
  logic          st_anyhalted, st_allhalted, st_anyrunning, st_allrunning;
  logic          st_anyresumeack, st_allresumeack, st_anyhavereset, st_allhavereset;
  logic          st_anyunavail, st_allunavail, st_nonexistent;
  logic [10:0]   stv;
  logic [11:0]   reqv;

  int checks = 0;
  int errors = 0;

  // req = {hart_halt, hart_resume, hart_reset} expected after an edge;
  // ctl = {haltreq, resumereq, hartreset} and acks are driven right after that sample.
  typedef struct {
    logic [11:0]   req;
    logic [2:0]    ctl;
    logic [NH-1:0] hack;
    logic [NH-1:0] rack;
    logic [NH-1:0] sack;
  } sb_t;
  sb_t sb_q[$];

  debug_hart_run_ctrl #(.NUM_HARTS(NH), .HARTSEL_W(HW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .hartsel(hartsel), .hasel(hasel), .hamask(hamask),
    .haltreq(haltreq), .resumereq(resumereq), .hartreset(hartreset), .ackhavereset(ackhavereset),
    .hart_halt_ack(hart_halt_ack), .hart_resume_ack(hart_resume_ack), .hart_reset_ack(hart_reset_ack),
    .hart_halt(hart_halt), .hart_resume(hart_resume), .hart_reset(hart_reset),
    .st_anyhalted(st_anyhalted), .st_allhalted(st_allhalted),
    .st_anyrunning(st_anyrunning), .st_allrunning(st_allrunning),
    .st_anyresumeack(st_anyresumeack), .st_allresumeack(st_allresumeack),
    .st_anyhavereset(st_anyhavereset), .st_allhavereset(st_allhavereset),
    .st_anyunavail(st_anyunavail), .st_allunavail(st_allunavail),
    .st_nonexistent(st_nonexistent)
  );

  always #5 clk = ~clk;

  assign stv  = {st_anyhalted, st_allhalted, st_anyrunning, st_allrunning, st_anyresumeack,
                 st_allresumeack, st_anyhavereset, st_allhavereset, st_anyunavail, st_allunavail,
                 st_nonexistent};
  assign reqv = {hart_halt, hart_resume, hart_reset};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] req, input logic [2:0] ctl,
                      input logic [NH-1:0] hack, input logic [NH-1:0] rack, input logic [NH-1:0] sack);
    sb_t e;
    e.req = req; e.ctl = ctl; e.hack = hack; e.rack = rack; e.sack = sack;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hartsel = '0; hasel = 1'b0; hamask = '0;
    haltreq = 1'b0; resumereq = 1'b0; hartreset = 1'b0; ackhavereset = 1'b0;
    hart_halt_ack = '0; hart_resume_ack = '0; hart_reset_ack = '0;
    repeat (3) tick();
    checks++;
    if (reqv !== 12'h000) begin
      errors++; $display("FAIL reset_req: got %b required %b", reqv, 12'h000);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (stv !== 11'b00_11_00_11_00_0) begin
      errors++; $display("FAIL reset_status: got %b required %b", stv, 11'b00_11_00_11_00_0);
    end
    hasel = 1'b1; hamask = 4'b1111; ackhavereset = 1'b1;
    tick();
    ackhavereset = 1'b0;
    checks++;
    if (stv !== 11'b00_11_00_00_00_0) begin
      errors++; $display("FAIL reset_ackhavereset: got %b required %b", stv, 11'b00_11_00_00_00_0);
    end
    hasel = 1'b0;
  endtask

  task automatic test_single_halt();
    sb_t e;
    hartsel = 5'd2; haltreq = 1'b1;
    push({4'b0100, 4'b0000, 4'b0000}, 3'b100, 4'b0000, '0, '0);
    push({4'b0100, 4'b0000, 4'b0000}, 3'b100, 4'b0000, '0, '0);
    push({4'b0100, 4'b0000, 4'b0000}, 3'b100, 4'b0100, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, 4'b0000, '0, '0);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL single_halt_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    checks++;
    if (stv !== 11'b11_00_00_00_00_0) begin
      errors++; $display("FAIL single_halt_status: got %b required %b", stv, 11'b11_00_00_00_00_0);
    end
  endtask

  task automatic test_array_resume();
    sb_t e;
    hartsel = 5'd0; hasel = 1'b1; hamask = 4'b1011; haltreq = 1'b1;
    push({4'b1011, 4'b0000, 4'b0000}, 3'b000, 4'b1011, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, 4'b0000, '0, '0);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL array_halt_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    hamask = 4'b1111;
    #1;
    checks++;
    if (stv !== 11'b11_00_00_00_00_0) begin
      errors++; $display("FAIL array_all_halted: got %b required %b", stv, 11'b11_00_00_00_00_0);
    end
    hamask = 4'b1010; resumereq = 1'b1;
    push({4'b0000, 4'b1011, 4'b0000}, 3'b000, '0, 4'b1011, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, '0, 4'b0000, '0);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL array_resume_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    checks++;
    if (stv !== 11'b00_11_11_00_00_0) begin
      errors++; $display("FAIL array_resumeack: got %b required %b", stv, 11'b00_11_11_00_00_0);
    end
    hasel = 1'b0; hartsel = 5'd2;
    #1;
    checks++;
    if (stv !== 11'b11_00_00_00_00_0) begin
      errors++; $display("FAIL array_hart2_halted: got %b required %b", stv, 11'b11_00_00_00_00_0);
    end
  endtask

  task automatic test_conflict();
    sb_t e;
    hartsel = 5'd1; hasel = 1'b0; haltreq = 1'b1;
    push({4'b0010, 4'b0000, 4'b0000}, 3'b110, 4'b0010, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b100, 4'b0000, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, 4'b0000, '0, '0);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL conflict_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    checks++;
    if (stv !== 11'b11_00_11_00_00_0) begin
      errors++; $display("FAIL conflict_status: got %b required %b", stv, 11'b11_00_11_00_00_0);
    end
  endtask

  task automatic test_timeout();
    sb_t e;
    hartsel = 5'd0; hasel = 1'b0; haltreq = 1'b1;
    for (int k = 0; k < TO; k++) push({4'b0001, 4'b0000, 4'b0000}, 3'b000, '0, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, '0, '0, '0);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL timeout_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    checks++;
    if (stv !== 11'b00_11_11_00_11_0) begin
      errors++; $display("FAIL timeout_status: got %b required %b", stv, 11'b00_11_11_00_11_0);
    end
  endtask

  task automatic test_reset_mid_resume();
    sb_t e;
    hartsel = 5'd3; hasel = 1'b0; haltreq = 1'b1;
    push({4'b1000, 4'b0000, 4'b0000}, 3'b000, 4'b1000, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b010, 4'b0000, '0, '0);
    push({4'b0000, 4'b1000, 4'b0000}, 3'b001, '0, '0, '0);
    push({4'b0000, 4'b0000, 4'b1000}, 3'b001, '0, '0, '0);
    push({4'b0000, 4'b0000, 4'b1000}, 3'b000, '0, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, '0, '0, 4'b1000);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, '0, '0, 4'b0000);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL reset_resume_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    checks++;
    if (stv !== 11'b00_11_00_11_00_0) begin
      errors++; $display("FAIL reset_resume_havereset: got %b required %b", stv, 11'b00_11_00_11_00_0);
    end
    ackhavereset = 1'b1;
    tick();
    ackhavereset = 1'b0;
    checks++;
    if (stv !== 11'b00_11_00_00_00_0) begin
      errors++; $display("FAIL reset_resume_ackhr: got %b required %b", stv, 11'b00_11_00_00_00_0);
    end
  endtask

  task automatic test_nonexistent();
    sb_t e;
    hartsel = 5'd7; hasel = 1'b0; haltreq = 1'b1;
    push({4'b0000, 4'b0000, 4'b0000}, 3'b100, '0, '0, '0);
    push({4'b0000, 4'b0000, 4'b0000}, 3'b000, '0, '0, '0);
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      checks++;
      if (reqv !== e.req) begin
        errors++; $display("FAIL nonexist_req: got %b required %b", reqv, e.req);
      end
      {haltreq, resumereq, hartreset} = e.ctl;
      hart_halt_ack = e.hack; hart_resume_ack = e.rack; hart_reset_ack = e.sack;
    end
    checks++;
    if (stv !== 11'b00_00_00_00_00_1) begin
      errors++; $display("FAIL nonexist_status: got %b required %b", stv, 11'b00_00_00_00_00_1);
    end
    hasel = 1'b1; hamask = 4'b1111;
    #1;
    checks++;
    if (stv !== 11'b10_10_10_00_10_1) begin
      errors++; $display("FAIL nonexist_array: got %b required %b", stv, 11'b10_10_10_00_10_1);
    end
    hasel = 1'b0;
  endtask

  task automatic test_async_reset();
    hartsel = 5'd0; haltreq = 1'b1;
    tick();
    checks++;
    if (reqv !== {4'b0001, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL async_pre_req: got %b required %b", reqv, {4'b0001, 8'h00});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (reqv !== 12'h000) begin
      errors++; $display("FAIL async_req: got %b required %b", reqv, 12'h000);
    end
    checks++;
    if (stv !== 11'b00_11_00_11_00_0) begin
      errors++; $display("FAIL async_status: got %b required %b", stv, 11'b00_11_00_11_00_0);
    end
    haltreq = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_halt();
    test_array_resume();
    test_conflict();
    test_timeout();
    test_reset_mid_resume();
    test_nonexistent();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
